stopwatch_ctrl: RTL

- Run/pause/lap/clear controller for the stopwatch digit chain (mod-10/mod-6 BCD counters).
- Synchronises and edge-detects the two front-panel buttons and runs a 4-state FSM.
- Generates the one-cycle count tick from a clock prescaler, a synchronous clear pulse for the counters, and a display-freeze signal for lap mode.
- Sits between the button inputs and the counter chain; the counters only count on tick_en and only zero on count_clear.

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: button synchronisers with rising-edge
// detection, a 4-state FSM, the count-tick prescaler, and the counter-clear and
// display-freeze controls for the BCD digit chain.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    input  logic       chain_max,
    output logic       tick_en,
    output logic       count_clear,
    output logic       display_hold,
    output logic       running,
    output logic [1:0] state
);
    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SYNC_STAGES-1:0] sp_sync_q, lp_sync_q;
    logic                   sp_prev_q, lp_prev_q;
    logic                   por_done_q;
    logic                   tick_q, tick_d;
    logic                   clear_q, clear_d;
    logic                   hold_q, hold_d;
    logic                   run_q, run_d;
    // a tick fell due while chain_max was high; forces PAUSE on the next edge
    logic                   sat_q, sat_d;
    logic                   sp_c, lp_c;
    logic                   due_c;

    // Button synchronisers followed by the previous-level flops for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_sync_q <= '0;
            lp_sync_q <= '0;
            sp_prev_q <= 1'b0;
            lp_prev_q <= 1'b0;
        end else begin
            sp_sync_q <= {sp_sync_q[SYNC_STAGES-2:0], btn_start_stop};
            lp_sync_q <= {lp_sync_q[SYNC_STAGES-2:0], btn_lap_reset};
            sp_prev_q <= sp_sync_q[SYNC_STAGES-1];
            lp_prev_q <= lp_sync_q[SYNC_STAGES-1];
        end
    end

    assign sp_c = sp_sync_q[SYNC_STAGES-1] & ~sp_prev_q;
    assign lp_c = lp_sync_q[SYNC_STAGES-1] & ~lp_prev_q;

    // FSM state, prescaler and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            por_done_q <= 1'b0;
            tick_q     <= 1'b0;
            clear_q    <= 1'b0;
            hold_q     <= 1'b0;
            run_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            por_done_q <= 1'b1;
            tick_q     <= tick_d;
            clear_q    <= clear_d;
            hold_q     <= hold_d;
            run_q      <= run_d;
            sat_q      <= sat_d;
        end
    end

    // Next-state, prescaler and output decode; start/stop wins over lap/reset
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        clear_d = ~por_done_q;
        tick_d  = 1'b0;
        sat_d   = 1'b0;
        due_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sp_c) begin
                    state_d = RUN;
                end else if (lp_c) begin
                    clear_d = 1'b1;
                end
            end
            RUN: begin
                if (sat_q || sp_c) begin
                    state_d = PAUSE;
                end else if (lp_c) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (sat_q || sp_c) begin
                    state_d = PAUSE;
                end else if (lp_c) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (sp_c) begin
                    state_d = RUN;
                end else if (lp_c) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // prescaler counts only while running; a fresh start begins at zero
        if ((state_q == RUN) || (state_q == LAP)) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end else if ((state_q == IDLE) && (state_d == RUN)) begin
            presc_d = '0;
        end

        run_d  = (state_d == RUN) || (state_d == LAP);
        hold_d = (state_d == LAP);
        due_c  = run_d && (presc_d == PRESC_MAX) && !clear_d;
        tick_d = due_c && !chain_max;
        sat_d  = due_c && chain_max;
    end

    assign tick_en      = tick_q;
    assign count_clear  = clear_q;
    assign display_hold = hold_q;
    assign running      = run_q;
    assign state        = state_q;

endmodule
